// File: rtl/lane_tx_scheduler_if.sv
// Symbol-lane bundle: TLP/DLLP source handshakes in, framed 8-bit lane out.
// master = source/lane consumer side, slave = scheduler side.
interface lane_tx_scheduler_if;
  logic       tlp_req;
  logic [7:0] tlp_data;
  logic       tlp_last;
  logic       tlp_ack;
  logic       dllp_req;
  logic [7:0] dllp_data;
  logic       dllp_last;
  logic       dllp_ack;
  logic       valid_out;
  logic [7:0] data_out;
  logic       ctrl_out;

  modport master (
    output tlp_req, tlp_data, tlp_last, dllp_req, dllp_data, dllp_last,
    input  tlp_ack, dllp_ack, valid_out, data_out, ctrl_out
  );

  modport slave (
    input  tlp_req, tlp_data, tlp_last, dllp_req, dllp_data, dllp_last,
    output tlp_ack, dllp_ack, valid_out, data_out, ctrl_out
  );
endinterface

// File: rtl/lane_tx_scheduler.sv
// Shares one 8-bit symbol lane between TLP, DLLP and SKP ordered sets, framing packets.
// Define LANE_SCHED_SKP_EN to build the periodic SKP timer and SKP ordered-set insertion.
module lane_tx_scheduler #(
  parameter int SKP_INTERVAL = 64,
  parameter int SKP_LEN      = 3
) (
  input  logic               clk,
  input  logic               reset_L,
  lane_tx_scheduler_if.slave bus
);
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_IDL = 8'h7C;
  localparam logic [7:0] SYM_COM = 8'hBC;

  typedef enum logic [2:0] {IDLE, SKP_OS, TLP_BODY, DLLP_BODY, PKT_END} state_t;

  state_t     state, state_n;
  logic       last_grant, last_grant_n;  // 1: DLLP was granted last
  logic [2:0] skp_cnt, skp_cnt_n;
  logic       skp_pending;
  logic       com_emit;
  logic       grant_tlp, grant_dllp;
  logic [7:0] sym_n;
  logic       ctrl_n;

  // Round-robin: on a tie the source not granted last wins.
  assign grant_tlp  = bus.tlp_req & (~bus.dllp_req | last_grant);
  assign grant_dllp = bus.dllp_req & ~grant_tlp;
  assign com_emit   = (state == IDLE) & skp_pending;

  assign bus.tlp_ack  = (state == TLP_BODY)  & bus.tlp_req;
  assign bus.dllp_ack = (state == DLLP_BODY) & bus.dllp_req;

`ifdef LANE_SCHED_SKP_EN
  localparam logic [15:0] SKP_WRAP = 16'(SKP_INTERVAL - 1);
  logic [15:0] skp_timer;
  logic        skp_wrap;

  assign skp_wrap = (skp_timer == SKP_WRAP);

  // A wrap while a request is still outstanding just keeps it pending.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      skp_timer   <= '0;
      skp_pending <= 1'b0;
    end else begin
      skp_timer   <= skp_wrap ? '0 : skp_timer + 16'd1;
      skp_pending <= skp_wrap | (skp_pending & ~com_emit);
    end
  end
`else
  // Never true for a legal interval, so no SKP ordered set is ever requested.
  assign skp_pending = (SKP_INTERVAL == 0);
`endif

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      skp_cnt    <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      skp_cnt    <= skp_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    skp_cnt_n    = skp_cnt;
    case (state)
      IDLE: begin
        if (skp_pending) begin
          state_n   = SKP_OS;
          skp_cnt_n = 3'(SKP_LEN);
        end else if (grant_tlp) begin
          state_n      = TLP_BODY;
          last_grant_n = 1'b0;
        end else if (grant_dllp) begin
          state_n      = DLLP_BODY;
          last_grant_n = 1'b1;
        end
      end
      SKP_OS: begin
        skp_cnt_n = skp_cnt - 3'd1;
        if (skp_cnt == 3'd1) state_n = IDLE;
      end
      TLP_BODY: begin
        if (!bus.tlp_req)      state_n = IDLE;
        else if (bus.tlp_last) state_n = PKT_END;
      end
      DLLP_BODY: begin
        if (!bus.dllp_req)      state_n = IDLE;
        else if (bus.dllp_last) state_n = PKT_END;
      end
      PKT_END: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Symbol chosen this cycle; it reaches the lane after the edge.
  always_comb begin
    sym_n  = SYM_IDL;
    ctrl_n = 1'b1;
    case (state)
      IDLE: begin
        if (skp_pending)     sym_n = SYM_COM;
        else if (grant_tlp)  sym_n = SYM_STP;
        else if (grant_dllp) sym_n = SYM_SDP;
      end
      SKP_OS: sym_n = SYM_SKP;
      TLP_BODY: begin
        if (bus.tlp_req) begin
          sym_n  = bus.tlp_data;
          ctrl_n = 1'b0;
        end else begin
          sym_n  = SYM_EDB;
        end
      end
      DLLP_BODY: begin
        if (bus.dllp_req) begin
          sym_n  = bus.dllp_data;
          ctrl_n = 1'b0;
        end else begin
          sym_n  = SYM_EDB;
        end
      end
      PKT_END: sym_n = SYM_END;
      default: sym_n = SYM_IDL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      bus.valid_out <= 1'b0;
      bus.data_out  <= 8'h00;
      bus.ctrl_out  <= 1'b0;
    end else begin
      bus.valid_out <= 1'b1;
      bus.data_out  <= sym_n;
      bus.ctrl_out  <= ctrl_n;
    end
  end
endmodule

// File: tb/tb_lane_tx_scheduler.sv
// Bench for lane_tx_scheduler: directed vector table, hand-written corner sequences
// and randomized traffic against a packet-level reference model.
module tb_lane_tx_scheduler;
  localparam int SKP_INTERVAL = 16;
  localparam int SKP_LEN      = 3;
`ifdef LANE_SCHED_SKP_EN
  localparam bit SKP_EN = 1'b1;
`else
  localparam bit SKP_EN = 1'b0;
`endif
  localparam logic [7:0] STP = 8'hFB, SDP = 8'h5C, ENDS = 8'hFD, EDB = 8'hFE;
  localparam logic [7:0] SKP = 8'h1C, IDL = 8'h7C, COM = 8'hBC;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  int   checks = 0;
  int   fails = 0;

  lane_tx_scheduler_if bus();

  lane_tx_scheduler #(.SKP_INTERVAL(SKP_INTERVAL), .SKP_LEN(SKP_LEN)) dut (
    .clk(clk), .reset_L(reset_L), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic tr, input logic [7:0] td, input logic tl,
                       input logic dr, input logic [7:0] dd, input logic dl);
    bus.tlp_req  = tr; bus.tlp_data  = td; bus.tlp_last  = tl;
    bus.dllp_req = dr; bus.dllp_data = dd; bus.dllp_last = dl;
  endtask

  // Reference model: who owns the lane, pending END, SKPs left to send.
  int m_owner;       // 0 none, 1 TLP, 2 DLLP
  bit m_end_due;
  int m_skp_left;
  bit m_prefer_tlp;
  bit m_pend;
  int m_edges;

  task automatic model_reset();
    m_owner = 0; m_end_due = 0; m_skp_left = 0;
    m_prefer_tlp = 1; m_pend = 0; m_edges = 0;
  endtask

  task automatic model_step(input logic tr, input logic [7:0] td, input logic tl,
                            input logic dr, input logic [7:0] dd, input logic dl,
                            output logic [7:0] sym, output logic ctrl,
                            output logic ta, output logic da);
    bit com;
    com  = 1'b0;
    ta   = (m_owner == 1) && tr;
    da   = (m_owner == 2) && dr;
    ctrl = 1'b1;
    if (m_skp_left > 0) begin
      sym = SKP; m_skp_left--;
    end else if (m_end_due) begin
      sym = ENDS; m_end_due = 0;
    end else if (m_owner == 1) begin
      if (tr) begin sym = td; ctrl = 1'b0; if (tl) begin m_end_due = 1; m_owner = 0; end end
      else begin sym = EDB; m_owner = 0; end
    end else if (m_owner == 2) begin
      if (dr) begin sym = dd; ctrl = 1'b0; if (dl) begin m_end_due = 1; m_owner = 0; end end
      else begin sym = EDB; m_owner = 0; end
    end else if (m_pend) begin
      sym = COM; m_skp_left = SKP_LEN; com = 1'b1;
    end else if (tr && (m_prefer_tlp || !dr)) begin
      sym = STP; m_owner = 1; m_prefer_tlp = 0;
    end else if (dr) begin
      sym = SDP; m_owner = 2; m_prefer_tlp = 1;
    end else begin
      sym = IDL;
    end
    m_edges++;
    if (SKP_EN) m_pend = ((m_edges % SKP_INTERVAL) == 0) || (m_pend && !com);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    reset_L = 1'b0;
    @(negedge clk);
    reset_L = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic tr; logic [7:0] td; logic tl;
    logic dr; logic [7:0] dd; logic dl;
    logic [7:0] sym; logic ctrl; logic ta; logic da;
  } vec_t;

  vec_t vec[15];

  task automatic run_table();
    vec[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, IDL,   1'b1, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, STP,   1'b1, 1'b0, 1'b0};
    vec[2]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b0};
    vec[3]  = '{1'b1, 8'hBB, 1'b0, 1'b1, 8'h33, 1'b1, 8'hBB, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{1'b1, 8'hCC, 1'b1, 1'b0, 8'h00, 1'b0, 8'hCC, 1'b0, 1'b1, 1'b0};
    vec[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, ENDS,  1'b1, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, IDL,   1'b1, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 8'hD0, 1'b0, 1'b0, 8'h00, 1'b0, STP,   1'b1, 1'b0, 1'b0};
    vec[8]  = '{1'b1, 8'hD0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hD0, 1'b0, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, EDB,   1'b1, 1'b0, 1'b0};
    vec[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, IDL,   1'b1, 1'b0, 1'b0};
    vec[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, SDP,   1'b1, 1'b0, 1'b0};
    vec[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1};
    vec[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, ENDS,  1'b1, 1'b0, 1'b0};
    vec[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, IDL,   1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 15; i++) begin
      drive(vec[i].tr, vec[i].td, vec[i].tl, vec[i].dr, vec[i].dd, vec[i].dl);
      #1;
      chk($sformatf("tbl%0d_tlp_ack", i), bus.tlp_ack, vec[i].ta);
      chk($sformatf("tbl%0d_dllp_ack", i), bus.dllp_ack, vec[i].da);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_data", i), bus.data_out, vec[i].sym);
      chk($sformatf("tbl%0d_ctrl", i), bus.ctrl_out, vec[i].ctrl);
      chk($sformatf("tbl%0d_valid", i), bus.valid_out, 1'b1);
      @(negedge clk);
    end
  endtask

  // Both sources request 2-byte packets back to back: STP/SDP alternate, no gaps.
  task automatic run_continuous();
    int tp, tpos, dp, dpos;
    logic ta, da;
    logic [7:0] exp;
    logic expc;
    int pkt, ph, n;
    tp = 0; tpos = 0; dp = 0; dpos = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(8'hA0 + tp * 2 + tpos), tpos == 1, 1'b1, 8'(8'hD0 + dp * 2 + dpos), dpos == 1);
      #1; ta = bus.tlp_ack; da = bus.dllp_ack;
      @(posedge clk); #1;
      pkt = i / 4; ph = i % 4; n = pkt / 2;
      expc = (ph == 0 || ph == 3);
      if (ph == 0)      exp = (pkt % 2 == 0) ? STP : SDP;
      else if (ph == 3) exp = ENDS;
      else              exp = (pkt % 2 == 0) ? 8'(8'hA0 + n * 2 + ph - 1) : 8'(8'hD0 + n * 2 + ph - 1);
      chk($sformatf("rr%0d_data", i), bus.data_out, exp);
      chk($sformatf("rr%0d_ctrl", i), bus.ctrl_out, expc);
      if (ta) begin if (tpos == 1) begin tpos = 0; tp++; end else tpos++; end
      if (da) begin if (dpos == 1) begin dpos = 0; dp++; end else dpos++; end
      @(negedge clk);
    end
  endtask

  task automatic run_mid_reset();
    drive(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1; chk("mr_stp", bus.data_out, STP);
    @(negedge clk); #1; chk("mr_ack", bus.tlp_ack, 1'b1);
    @(posedge clk); #1; chk("mr_byte", bus.data_out, 8'h11);
    @(negedge clk);
    drive(1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0);
    #2 reset_L = 1'b0;
    #1;
    chk("mr_valid0", bus.valid_out, 1'b0);
    chk("mr_data0", bus.data_out, 8'h00);
    chk("mr_ctrl0", bus.ctrl_out, 1'b0);
    chk("mr_ack0", bus.tlp_ack, 1'b0);
    @(negedge clk);
    reset_L = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1; chk("mr_idl", bus.data_out, IDL); chk("mr_idl_ctrl", bus.ctrl_out, 1'b1);
    @(negedge clk);
    drive(1'b1, 8'h31, 1'b1, 1'b1, 8'h41, 1'b1);
    @(posedge clk); #1; chk("mr_tie_stp", bus.data_out, STP);
    @(negedge clk); #1; chk("mr_tack", bus.tlp_ack, 1'b1); chk("mr_dack", bus.dllp_ack, 1'b0);
    @(posedge clk); #1; chk("mr_tbyte", bus.data_out, 8'h31);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 1'b1);
    @(posedge clk); #1; chk("mr_end", bus.data_out, ENDS);
    @(negedge clk);
    @(posedge clk); #1; chk("mr_sdp", bus.data_out, SDP);
    @(negedge clk);
  endtask

  // 20-byte TLPs back to back; the wrap at edge 16 lands mid-packet.
  task automatic run_skp_midpacket();
    int tpos;
    logic ta;
    logic [7:0] exp;
    logic expc;
    tpos = 0;
    for (int e = 1; e <= 27; e++) begin
      drive(1'b1, 8'(8'h40 + tpos), tpos == 19, 1'b0, 8'h00, 1'b0);
      #1; ta = bus.tlp_ack;
      @(posedge clk); #1;
      expc = 1'b1;
      if (e == 1) exp = STP;
      else if (e <= 21) begin exp = 8'(8'h40 + e - 2); expc = 1'b0; end
      else if (e == 22) exp = ENDS;
      else if (SKP_EN) exp = (e == 23) ? COM : (e <= 26) ? SKP : STP;
      else if (e == 23) exp = STP;
      else begin exp = 8'(8'h40 + e - 24); expc = 1'b0; end
      chk($sformatf("skp_e%0d_data", e), bus.data_out, exp);
      chk($sformatf("skp_e%0d_ctrl", e), bus.ctrl_out, expc);
      if (ta) tpos = (tpos == 19) ? 0 : tpos + 1;
      @(negedge clk);
    end
  endtask

  task automatic rand_run(input int ncyc);
    int len[2], pos[2], drop[2], gap[2];
    bit has_pkt[2];
    logic [7:0] base[2], d[2];
    logic r[2], l[2], a[2];
    logic [7:0] es;
    logic ec, eta, eda;
    for (int s = 0; s < 2; s++) begin
      gap[s] = $urandom_range(0, 3); has_pkt[s] = 0; pos[s] = 0; len[s] = 1; drop[s] = -1; base[s] = 8'h00;
    end
    for (int c = 0; c < ncyc; c++) begin
      for (int s = 0; s < 2; s++) begin
        if (!has_pkt[s]) begin
          if (gap[s] > 0) gap[s]--;
          else begin
            has_pkt[s] = 1; pos[s] = 0; len[s] = $urandom_range(1, 6); base[s] = 8'($urandom);
            drop[s] = (len[s] > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len[s] - 1)) : -1;
          end
        end
        r[s] = has_pkt[s] && (pos[s] != drop[s]);
        d[s] = base[s] + 8'(pos[s] * 37);
        l[s] = (pos[s] == len[s] - 1);
      end
      drive(r[0], d[0], l[0], r[1], d[1], l[1]);
      model_step(r[0], d[0], l[0], r[1], d[1], l[1], es, ec, eta, eda);
      #1;
      a[0] = bus.tlp_ack; a[1] = bus.dllp_ack;
      chk("rnd_tlp_ack", a[0], eta);
      chk("rnd_dllp_ack", a[1], eda);
      @(posedge clk); #1;
      chk("rnd_data", bus.data_out, es);
      chk("rnd_ctrl", bus.ctrl_out, ec);
      chk("rnd_valid", bus.valid_out, 1'b1);
      for (int s = 0; s < 2; s++) begin
        if (has_pkt[s]) begin
          if (!r[s]) begin has_pkt[s] = 0; gap[s] = $urandom_range(0, 3); end
          else if (a[s]) begin
            pos[s]++;
            if (pos[s] == len[s]) begin has_pkt[s] = 0; gap[s] = $urandom_range(0, 3); end
          end
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] exp;
    drive(1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    #2;
    chk("rst_valid", bus.valid_out, 1'b0);
    chk("rst_data", bus.data_out, 8'h00);
    chk("rst_ctrl", bus.ctrl_out, 1'b0);
    chk("rst_tlp_ack", bus.tlp_ack, 1'b0);
    chk("rst_dllp_ack", bus.dllp_ack, 1'b0);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    reset_L = 1'b1;
    for (int e = 1; e <= 21; e++) begin
      @(posedge clk); #1;
      if (SKP_EN && e == 17) exp = COM;
      else if (SKP_EN && e >= 18 && e <= 20) exp = SKP;
      else exp = IDL;
      chk($sformatf("idle_e%0d_data", e), bus.data_out, exp);
      chk($sformatf("idle_e%0d_ctrl", e), bus.ctrl_out, 1'b1);
      chk($sformatf("idle_e%0d_valid", e), bus.valid_out, 1'b1);
      @(negedge clk);
    end
    do_reset(); run_table();
    do_reset(); run_continuous();
    do_reset(); run_mid_reset();
    do_reset(); run_skp_midpacket();
    do_reset(); rand_run(3000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
